// File: rtl/fc_pkg.sv
// Shared constants and types for the fc layer and its downstream classifier stage.
package fc_pkg;

  localparam int FC_WIDTH = 16;
  localparam int FC_OUT_N = 8;

  typedef logic signed [FC_WIDTH-1:0] fc_data_t;

  typedef enum {OUT_EMPTY, OUT_FULL} out_state_t;

endpackage

// File: rtl/fc_argmax_8_16.sv
// Argmax classifier: scans N signed words per vector and emits {max value, index}.
// The next vector's scan overlaps with holding the previous result in the output register.
module fc_argmax_8_16
  import fc_pkg::*;
#(
  parameter int  WIDTH = FC_WIDTH,
  parameter int  N     = FC_OUT_N,
  localparam int LOGN  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic signed [WIDTH-1:0] input_data,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic signed [WIDTH-1:0] output_data,
  output logic [LOGN-1:0]         output_index
);

  // Handshakes: a word moves when input_valid & input_ready, a result moves when
  // output_valid & output_ready, both at the rising edge of clk.
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  logic [LOGN-1:0]         cnt;
  logic signed [WIDTH-1:0] best_val;
  logic [LOGN-1:0]         best_idx;

  out_state_t state, state_next;

  logic                    in_xfer, out_xfer, at_last, complete, take;
  logic signed [WIDTH-1:0] win_val;
  logic [LOGN-1:0]         win_idx;

  // output_ready reaches input_ready combinationally: the last word of a vector is
  // accepted in the same cycle the pending result is taken downstream.
  assign at_last     = (cnt == LAST);
  assign input_ready = !(at_last && output_valid && !output_ready);
  assign in_xfer     = input_valid && input_ready;
  assign out_xfer    = output_valid && output_ready;
  assign complete    = in_xfer && at_last;

  // Strict greater-than keeps the earliest index on ties; word 0 always loads.
  assign take    = (cnt == '0) || (input_data > best_val);
  assign win_val = take ? input_data : best_val;
  assign win_idx = take ? cnt : best_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else if (in_xfer) begin
      cnt      <= at_last ? '0 : cnt + 1'b1;
      best_val <= win_val;
      best_idx <= win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      output_data  <= '0;
      output_index <= '0;
    end else if (complete) begin
      output_data  <= win_val;
      output_index <= win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= OUT_EMPTY;
    else       state <= state_next;
  end

  // A completion while FULL only happens together with out_xfer (input_ready
  // guarantees it), so FULL simply stays FULL and the new result replaces the old.
  always_comb begin
    state_next = state;
    case (state)
      OUT_EMPTY: if (complete) state_next = OUT_FULL;
      OUT_FULL:  if (out_xfer && !complete) state_next = OUT_EMPTY;
      default:   state_next = OUT_EMPTY;
    endcase
  end

  always_comb begin
    output_valid = (state == OUT_FULL);
  end

endmodule

// File: doc/fc_argmax_8_16.md
Name: fc_argmax_8_16

Overview:
- Classifier stage directly downstream of the final fc layer (fc_8_8_16_1_1, W_M=8 outputs of 16 bits).
- Consumes the layer's output stream of N signed words per input vector over a valid/ready handshake.
- Emits one result per vector: the maximum value and its index (class label).
- Overlaps the scan of vector k+1 with the holding of result k, so the upstream fc layer stalls only at vector end.

Parameters:
- WIDTH, 16, signed data width; matches the fc layer's WIDTH.
- N, 8, words per vector; matches the fc layer's W_M.
- LOGN, $clog2(N) (minimum 1), width of the index and counter. Localparam.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- input_valid  in  1  upstream word valid.
- input_ready  out  1  block can accept a word this cycle.
- input_data  in  WIDTH  signed word, in index order 0..N-1.
- output_valid  out  1  result register holds an unconsumed result.
- output_ready  in  1  downstream accepts the result.
- output_data  out  WIDTH  signed maximum value of the vector.
- output_index  out  LOGN  index (0..N-1) of the maximum.

Behaviour:
- Handshakes: in_xfer = input_valid & input_ready; out_xfer = output_valid & output_ready.
- Scan state:
  - cnt: 0..N-1, the index of the next expected word.
  - best_val (WIDTH, signed) and best_idx (LOGN): running maximum and its index.
- cnt update on in_xfer:
  - cnt < N-1: cnt <= cnt+1.
  - cnt == N-1: cnt <= 0 (wrap).
  - No change without in_xfer. Upstream gaps (input_valid low) are tolerated at any point in a vector.
- Running maximum on in_xfer:
  - cnt == 0: best_val <= input_data, best_idx <= 0 (unconditional load).
  - Otherwise, if input_data > best_val under a signed compare: best_val <= input_data, best_idx <= cnt.
  - Ties keep the earlier (lower) index.
- Completion: in_xfer with cnt == N-1.
  - Final compare is combinational on best_val/best_idx vs input_data (cnt == 0 load rule applies when N == 1).
  - Winner goes straight into output_data/output_index; output_valid <= 1.
  - Latency: result visible the cycle after the last word is accepted.
- Output register, 2-state FSM:
  - EMPTY (output_valid = 0): go to FULL on completion.
  - FULL (output_valid = 1):
    - out_xfer and no completion: go to EMPTY.
    - out_xfer and completion in the same cycle: load the new result and stay FULL (no bubble).
    - Completion without out_xfer cannot happen; input_ready prevents it.
  - output_data and output_index stay stable while FULL and not consumed.
- input_ready = !(cnt == N-1 && output_valid && !output_ready).
  - Words 0..N-2 are always accepted, even while a result is pending.
  - Combinational path from output_ready to input_ready is allowed. Document it for integration.
- Reset values: cnt = 0, best_val = 0, best_idx = 0, output_valid = 0, output_data = 0, output_index = 0. input_ready = 1 after reset.
- Reset mid-vector discards the partial scan and any pending result. Reset takes priority over every transfer in that cycle.
- Arithmetic:
  - Pure signed compare, no saturation needed.
  - Full range -2^(WIDTH-1)..2^(WIDTH-1)-1 handled.
  - An all-negative vector must return its true (negative) maximum, not 0.
- Wrap-around: cnt wraps N-1 -> 0 with no idle cycle, so back-to-back vectors stream at one word per cycle.

Decomposition:
- Shared package fc_pkg:
  - FC_WIDTH = 16, FC_OUT_N = 8.
  - typedef logic signed [FC_WIDTH-1:0] fc_data_t.
  - typedef enum {OUT_EMPTY, OUT_FULL} out_state_t.
- No sub-module required. Compare/update logic, counter, and output FSM live in one module of about 130-180 lines.

Test Plan:
- Reset, then stream [3,-1,7,2,7,0,-5,1] with output_ready = 1 -> one cycle after word 7 is accepted: output_valid = 1, output_data = 7, output_index = 2 (tie keeps index 2).
- All-negative [-9,-4,-32768,-4,-100,-7,-20,-5] -> output_data = -4, output_index = 1. Then [32767,0,0,0,0,0,0,32767] -> output_data = 32767, output_index = 0.
- Hold output_ready = 0 across two back-to-back vectors -> words 0-6 of vector 2 accepted; input_ready = 0 at word 7; the first result stays stable; raising output_ready accepts word 7 in the same cycle; the next cycle shows the second result with output_valid still high.
- Random input_valid gaps (~50%) with random output_ready over 1000 vectors -> results match the reference argmax in order, with no loss or duplication.
- Assert reset after word 4 of a vector, then send a fresh vector [0,0,0,0,0,0,9,0] -> output_data = 9, output_index = 6; no stale result is emitted.
